// File: rtl/sp_rf_waddr_pipe.sv
// sp_rf_waddr_pipe: destination-register pipeline EX->DF->WB with RD-stage bypass selects and load-use interlock
module sp_rf_waddr_pipe #(
    parameter int ADDR_W      = 5,
    parameter bit R0_WRITABLE = 1'b0
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              stall,
    input  logic              iss_valid,
    input  logic              iss_wen,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic              iss_is_load,
    input  logic              ex_kill,
    input  logic [ADDR_W-1:0] rd_rs,
    input  logic [ADDR_W-1:0] rd_rt,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic              wb_wen,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              load_use
);
    logic              ex_v, df_v, wb_v, ex_ld, df_ld, wb_ld, wb_done, q;
    logic [ADDR_W-1:0] ex_addr, df_addr, wb_addr;

    assign q        = iss_valid & iss_wen & (R0_WRITABLE | (iss_waddr != '0));
    assign wb_wen   = wb_v & ~wb_done;
    assign wb_waddr = wb_addr;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            {ex_v, df_v, wb_v, ex_ld, df_ld, wb_ld, wb_done} <= '0;
            {ex_addr, df_addr, wb_addr} <= '0;
        end else if (!stall) begin
            ex_v    <= q;
            ex_addr <= iss_waddr;
            ex_ld   <= iss_is_load;
            df_v    <= ex_v & ~ex_kill;
            df_addr <= ex_addr;
            df_ld   <= ex_ld;
            wb_v    <= df_v;
            wb_addr <= df_addr;
            wb_ld   <= df_ld;
            wb_done <= 1'b0;
        end else begin
            if (ex_kill) ex_v <= 1'b0;
            // a frozen WB entry writes on its first stalled edge only
            if (wb_wen) wb_done <= 1'b1;
        end
    end

    function automatic logic [1:0] byp(input logic [ADDR_W-1:0] x);
        return (!R0_WRITABLE && x == '0)  ? 2'b00 :
               (ex_v && ex_addr == x)     ? (ex_ld ? 2'b00 : 2'b01) :
               (df_v && df_addr == x)     ? 2'b10 :
               (wb_v && wb_addr == x)     ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        fwd_rs_sel = byp(rd_rs);
        fwd_rt_sel = byp(rd_rt);
        load_use   = ex_v & ex_ld &
                     ((ex_addr == rd_rs && (R0_WRITABLE || rd_rs != '0)) ||
                      (ex_addr == rd_rt && (R0_WRITABLE || rd_rt != '0)));
    end
endmodule
